// File: rtl/sqr_wav_pkg.sv
// -----------------------------------------------------------------------------
// sqr_wav_pkg
//   Shared types and helpers for the square-wave measurement block.
//   - meas_state_t : measurement FSM state encoding
//   - M_MAX        : largest representable m/n value (also the saturation value)
//   - meas_div     : clock cycles per m/n unit
//   - meas_timeout : clock cycles without an edge that declare the input stuck
// -----------------------------------------------------------------------------
package sqr_wav_pkg;

  typedef enum logic [1:0] {
    WAIT_EDGE = 2'd0,
    MEAS_HIGH = 2'd1,
    MEAS_LOW  = 2'd2,
    STUCK     = 2'd3
  } meas_state_t;

  localparam logic [3:0] M_MAX = 4'hF;

  // Clock cycles per m/n unit. UNIT_NS must be an integer multiple of CLK_NS
  // and the ratio must be at least 2 so that half a unit is a whole cycle.
  function automatic int meas_div(input int unit_ns, input int clk_ns);
    return unit_ns / clk_ns;
  endfunction

  // Number of cycles without an edge after which the input is declared stuck.
  function automatic int meas_timeout(input int timeout_units, input int div);
    return timeout_units * div;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
//   Brings an asynchronous level into the clk domain through SYNC_STAGES
//   flops and produces registered one-cycle rise/fall strobes.
//
//   Ports
//     clk    in   system clock
//     rst_n  in   synchronous active-low reset
//     din    in   asynchronous input level
//     level  out  synchronised level, aligned with the strobes (it already
//                 shows the new level in the cycle a strobe is high)
//     rise   out  one-cycle strobe: synchronised level went 0 -> 1
//     fall   out  one-cycle strobe: synchronised level went 1 -> 0
//
//   Timing: din first sampled high at edge k -> rise high in the cycle after
//   edge k+SYNC_STAGES.
// -----------------------------------------------------------------------------
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
      // Strobes are registered so that they and 'level' change together.
      rise   <= sync_q[SYNC_STAGES-1] & ~prev_q;
      fall   <= ~sync_q[SYNC_STAGES-1] & prev_q;
    end
  end

  assign level = prev_q;

endmodule

// File: rtl/sqr_wav_meas.sv
// -----------------------------------------------------------------------------
// sqr_wav_meas
//   Receive-side measurement of a square wave. Recovers the high time (m) and
//   low time (n) in UNIT_NS units, using the same encoding as the square-wave
//   generator: m=0 means stuck low, n=0 with m=15 means stuck high.
//
//   Ports
//     clk         in   system clock
//     rst_n       in   synchronous active-low reset
//     sqr_in      in   square wave under measurement, asynchronous
//     high_m[3:0] out  last measured high time, units
//     low_n[3:0]  out  last measured low time, units
//     meas_valid  out  one-cycle pulse: high_m/low_n/stuck just updated
//     locked      out  a full high+low period was measured since reset/stuck
//     stuck       out  input held one level for TIMEOUT_UNITS or longer
//     state_dbg   out  current measurement FSM state
//
//   Output protocol: meas_valid is a single-cycle strobe with no back-pressure;
//   high_m, low_n, stuck and locked change only in the cycle meas_valid is
//   high (or on reset) and hold their value otherwise. meas_valid is never
//   high in two consecutive cycles.
//
//   Latency: sqr_in first sampled high at clk edge k -> meas_valid and the new
//   outputs are visible in cycle k+SYNC_STAGES+1.
// -----------------------------------------------------------------------------
module sqr_wav_meas
  import sqr_wav_pkg::*;
#(
  parameter int UNIT_NS       = 100,
  parameter int CLK_NS        = 10,
  parameter int SYNC_STAGES   = 2,
  parameter int TIMEOUT_UNITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sqr_in,
  output logic [3:0]  high_m,
  output logic [3:0]  low_n,
  output logic        meas_valid,
  output logic        locked,
  output logic        stuck,
  output meas_state_t state_dbg
);

  localparam int DIV         = meas_div(UNIT_NS, CLK_NS);
  localparam int TIMEOUT_CYC = meas_timeout(TIMEOUT_UNITS, DIV);
  localparam int PW          = $clog2(TIMEOUT_CYC + 1);
  localparam int SW          = $clog2(DIV);

  localparam logic [PW-1:0] PHASE_MAX = PW'(TIMEOUT_CYC);
  localparam logic [SW-1:0] PRESC_TOP = SW'(DIV - 1);

  // The prescaler tracks (phase_cyc + DIV/2) mod DIV and the unit counter
  // tracks floor((phase_cyc + DIV/2) / DIV). In the strobe cycle phase_cyc
  // reloads to 1, so both start from their values at phase_cyc = 1. This
  // gives round-half-up without a divider.
  localparam logic [SW-1:0] PRESC_RELOAD = SW'((1 + DIV / 2) % DIV);
  localparam logic [3:0]    UNIT_RELOAD  = 4'((1 + DIV / 2) / DIV);

  // ---------------------------------------------------------------------------
  // Front end
  // ---------------------------------------------------------------------------
  logic level;
  logic rise;
  logic fall;
  logic edge_stb;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_det (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sqr_in),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  assign edge_stb = rise | fall;

  // ---------------------------------------------------------------------------
  // Phase counter, prescaler and unit counter
  //   In a strobe cycle phase_cyc holds the number of cycles the previous
  //   level lasted and units holds that length converted to m/n units.
  // ---------------------------------------------------------------------------
  logic [PW-1:0] phase_cyc;
  logic [SW-1:0] presc;
  logic [3:0]    units;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_cyc <= '0;
      presc     <= '0;
      units     <= '0;
    end else if (edge_stb) begin
      phase_cyc <= PW'(1);
      presc     <= PRESC_RELOAD;
      units     <= UNIT_RELOAD;
    end else begin
      if (phase_cyc != PHASE_MAX) begin
        phase_cyc <= phase_cyc + 1'b1;
      end
      if (presc == PRESC_TOP) begin
        presc <= '0;
        if (units != M_MAX) begin
          units <= units + 1'b1;
        end
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Measurement FSM
  // ---------------------------------------------------------------------------
  meas_state_t state;
  logic [3:0]  high_hold;
  logic        hold_valid;
  logic        timeout;

  // The counter sits at PHASE_MAX once saturated; STUCK is excluded so the
  // stuck report is published only once. An edge in the same cycle wins.
  assign timeout = (phase_cyc == PHASE_MAX) && !edge_stb && (state != STUCK);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= WAIT_EDGE;
      high_hold  <= '0;
      hold_valid <= 1'b0;
      high_m     <= '0;
      low_n      <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      meas_valid <= 1'b0;

      if (timeout) begin
        // Report using the generator's encoding of a constant output.
        high_m     <= level ? M_MAX : 4'd0;
        low_n      <= 4'd0;
        stuck      <= 1'b1;
        locked     <= 1'b0;
        meas_valid <= 1'b1;
        hold_valid <= 1'b0;
        state      <= STUCK;
      end else begin
        case (state)
          WAIT_EDGE: begin
            // The phase running before the first edge is partial: discard it.
            if (rise) begin
              hold_valid <= 1'b0;
              state      <= MEAS_HIGH;
            end else if (fall) begin
              hold_valid <= 1'b0;
              state      <= MEAS_LOW;
            end
          end

          MEAS_HIGH: begin
            if (fall) begin
              high_hold  <= units;
              hold_valid <= 1'b1;
              state      <= MEAS_LOW;
            end
          end

          MEAS_LOW: begin
            if (rise) begin
              if (hold_valid) begin
                high_m     <= high_hold;
                low_n      <= units;
                stuck      <= 1'b0;
                locked     <= 1'b1;
                meas_valid <= 1'b1;
              end
              hold_valid <= 1'b0;
              state      <= MEAS_HIGH;
            end
          end

          STUCK: begin
            // Outputs keep the stuck report until the next full period.
            if (rise) begin
              hold_valid <= 1'b0;
              state      <= MEAS_HIGH;
            end else if (fall) begin
              hold_valid <= 1'b0;
              state      <= MEAS_LOW;
            end
          end

          default: begin
            hold_valid <= 1'b0;
            state      <= WAIT_EDGE;
          end
        endcase
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_sqr_wav_meas.sv
// -----------------------------------------------------------------------------
// tb_sqr_wav_meas
//   Directed stimulus on sqr_in with hand-computed publishes. Each expected
//   publish record {cycle, high_m, low_n, stuck, locked} is queued when the
//   edge that triggers it is driven; a monitor pops and compares whenever
//   meas_valid is seen.
//   Cycle bookkeeping: cyc counts posedges. Inputs change on a negedge where
//   cyc = c; a rise-triggered publish is then visible at the negedge where
//   cyc = c + 4 (2 sync stages + strobe register + output register) and a
//   timeout publish at c + 4 + 160.
// -----------------------------------------------------------------------------
module tb_sqr_wav_meas;
  import sqr_wav_pkg::*;

  localparam int W      = 42;
  localparam int LAT    = 4;
  localparam int TO_LAT = 164;

  logic        clk;
  logic        rst_n;
  logic        sqr_in;
  logic [3:0]  high_m;
  logic [3:0]  low_n;
  logic        meas_valid;
  logic        locked;
  logic        stuck;
  meas_state_t state_dbg;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  logic        prev_valid = 1'b0;
  logic [W-1:0] exp_q[$];

  sqr_wav_meas #(
    .UNIT_NS       (100),
    .CLK_NS        (10),
    .SYNC_STAGES   (2),
    .TIMEOUT_UNITS (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sqr_in     (sqr_in),
    .high_m     (high_m),
    .low_n      (low_n),
    .meas_valid (meas_valid),
    .locked     (locked),
    .stuck      (stuck),
    .state_dbg  (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Clock / cycle counter
  // ---------------------------------------------------------------------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Driver tasks (always entered and left on a negedge)
  // ---------------------------------------------------------------------------
  task automatic drive(input logic lvl, input int cycles);
    sqr_in = lvl;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic expect_pub(input logic [3:0] h, input logic [3:0] l,
                            input logic s, input logic lk, input int unsigned at);
    exp_q.push_back({at, h, l, s, lk});
  endtask

  // Publish triggered by the rise about to be driven.
  task automatic expect_rise(input logic [3:0] h, input logic [3:0] l);
    expect_pub(h, l, 1'b0, 1'b1, cyc + LAT);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    if (rst_n && meas_valid) begin
      got = {cyc, high_m, low_n, stuck, locked};
      if (prev_valid) begin
        n_checks++;
        n_fail++;
        $display("FAIL meas_valid_back_to_back: high at cycles %0d and %0d", cyc - 1, cyc);
      end
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_publish: cyc=%0d m=%0d n=%0d stuck=%0b locked=%0b, none expected",
                 cyc, high_m, low_n, stuck, locked);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("FAIL publish: got cyc=%0d m=%0d n=%0d stuck=%0b locked=%0b, expected cyc=%0d m=%0d n=%0d stuck=%0b locked=%0b",
                   got[41:10], got[9:6], got[5:2], got[1], got[0],
                   exp[41:10], exp[9:6], exp[5:2], exp[1], exp[0]);
        end
      end
    end
    prev_valid = rst_n && meas_valid;
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst_n  = 1'b0;
    sqr_in = 1'b0;
    repeat (5) @(negedge clk);

    // Reset state
    check("rst_high_m", 32'(high_m), 0);
    check("rst_low_n", 32'(low_n), 0);
    check("rst_meas_valid", 32'(meas_valid), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_stuck", 32'(stuck), 0);
    check("rst_state", 32'(state_dbg), 32'(WAIT_EDGE));
    rst_n = 1'b1;

    // m=3, n=2: partial low discarded, first publish after one full period,
    // then one publish every 50 cycles (exact cycles are in the records).
    drive(1'b0, 20);
    drive(1'b1, 30);
    drive(1'b0, 20);
    check("no_publish_before_full_period", 32'(locked), 0);
    for (int i = 0; i < 3; i++) begin
      expect_rise(4'd3, 4'd2);
      drive(1'b1, 30);
      drive(1'b0, 20);
    end
    check("locked_after_3_2", 32'(locked), 1);

    // m=15, n=1 then m=1, n=15
    expect_rise(4'd3, 4'd2);
    drive(1'b1, 150);
    drive(1'b0, 10);
    expect_rise(4'd15, 4'd1);
    drive(1'b1, 10);
    drive(1'b0, 150);
    expect_rise(4'd1, 4'd15);

    // Hand-driven phases: 14 -> 1, 15 -> 2, 4 -> 0, 170 -> stuck high
    drive(1'b1, 14);
    drive(1'b0, 20);
    expect_rise(4'd1, 4'd2);
    drive(1'b1, 15);
    drive(1'b0, 20);
    expect_rise(4'd2, 4'd2);
    drive(1'b1, 4);
    drive(1'b0, 20);
    expect_rise(4'd0, 4'd2);
    expect_pub(4'd15, 4'd0, 1'b1, 1'b0, cyc + TO_LAT);
    drive(1'b1, 170);
    check("stuck_high_flag", 32'(stuck), 1);
    check("stuck_high_m", 32'(high_m), 15);

    // Resume with m=2, n=2: first low after stuck is partial, no publish
    // until a complete high+low, stuck held until then.
    drive(1'b0, 20);
    drive(1'b1, 20);
    check("stuck_held_until_publish", 32'(stuck), 1);
    check("locked_low_while_stuck", 32'(locked), 0);
    drive(1'b0, 20);
    expect_rise(4'd2, 4'd2);
    drive(1'b1, 20);
    check("stuck_cleared", 32'(stuck), 0);
    drive(1'b0, 20);
    expect_rise(4'd2, 4'd2);
    drive(1'b1, 20);

    // Hold low 300 cycles: exactly one stuck-low publish 160 cycles after the fall
    expect_pub(4'd0, 4'd0, 1'b1, 1'b0, cyc + TO_LAT);
    drive(1'b0, 300);
    check("stuck_low_single_publish", 32'(exp_q.size()), 0);
    check("stuck_low_flag", 32'(stuck), 1);
    check("stuck_low_locked", 32'(locked), 0);
    check("stuck_low_n", 32'(low_n), 0);

    // Leave stuck low, publish once, then reset in the middle of MEAS_LOW
    drive(1'b1, 20);
    drive(1'b0, 20);
    expect_rise(4'd2, 4'd2);
    drive(1'b1, 20);
    drive(1'b0, 8);
    check("pre_reset_state", 32'(state_dbg), 32'(MEAS_LOW));
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_high_m", 32'(high_m), 0);
    check("mid_rst_low_n", 32'(low_n), 0);
    check("mid_rst_locked", 32'(locked), 0);
    check("mid_rst_stuck", 32'(stuck), 0);
    check("mid_rst_state", 32'(state_dbg), 32'(WAIT_EDGE));
    rst_n = 1'b1;
    drive(1'b0, 12);
    drive(1'b1, 30);
    drive(1'b0, 20);
    check("no_publish_after_reset_yet", 32'(locked), 0);
    expect_rise(4'd3, 4'd2);
    drive(1'b1, 30);
    drive(1'b0, 20);
    check("relocked_after_reset", 32'(locked), 1);

    check("all_publishes_seen", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
